// File: rtl/deit_pkg.sv
// deit_pkg: scheduler FSM state type and DMA descriptor type codes.
package deit_pkg;
  typedef enum logic [3:0] {
    IDLE, CFG, WT_REQ, WT_WAIT, IN_REQ, IN_WAIT, OUT_WAIT, NEXT, DONE
  } sched_state_e;
  localparam logic DMA_TYPE_WEIGHT = 1'b0;
  localparam logic DMA_TYPE_INPUT  = 1'b1;
endpackage

// File: rtl/deit_tile_counter.sv
// deit_tile_counter: nested tile counter, k inner and n outer, with last-index flags.
module deit_tile_counter #(
  parameter int K_W = 8,
  parameter int N_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           step,
  input  logic [K_W-1:0] k_tiles,
  input  logic [N_W-1:0] n_tiles,
  output logic [K_W-1:0] k,
  output logic [N_W-1:0] n,
  output logic           k_last,
  output logic           n_last
);
  assign k_last = k == k_tiles - K_W'(1);
  assign n_last = n == n_tiles - N_W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      k <= '0;
      n <= '0;
    end else if (clear) begin
      k <= '0;
      n <= '0;
    end else if (step) begin
      k <= k_last ? '0 : k + K_W'(1);
      n <= k_last ? n + N_W'(1) : n;
    end
endmodule

// File: rtl/deit_tile_scheduler.sv
// deit_tile_scheduler: walks the N/K tile loops, starting the core and issuing DMA descriptors.
// Optional perf counters are built when DEIT_TILE_SCHED_PERF_EN is defined.
module deit_tile_scheduler
  import deit_pkg::*;
#(
  parameter int K_W = 8,
  parameter int N_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [K_W-1:0] cfg_k_tiles,
  input  logic [N_W-1:0] cfg_n_tiles,
  input  logic           sched_start,
  input  logic           sched_abort,
  output logic           sched_busy,
  output logic           sched_done,
  output logic           sched_err,
  output logic           dma_req_valid,
  input  logic           dma_req_ready,
  output logic           dma_req_type,
  output logic [K_W-1:0] dma_req_k,
  output logic [N_W-1:0] dma_req_n,
  input  logic           wt_loaded,
  input  logic           in_done,
  input  logic           out_tvalid,
  input  logic           out_tready,
  input  logic           out_tlast,
  output logic           core_start,
  output logic           core_acc_mode,
  output logic           core_out_en
`ifdef DEIT_TILE_SCHED_PERF_EN
  ,
  output logic [31:0]    perf_cycles,
  output logic [31:0]    perf_stall
`endif
);
  sched_state_e state, nxt;
  logic [K_W-1:0] k_tiles_q, k;
  logic [N_W-1:0] n_tiles_q, n;
  logic k_last, n_last, start_req, start_ok;
  assign start_req = state == IDLE && sched_start && !sched_abort;
  assign start_ok = start_req && cfg_k_tiles != '0 && cfg_n_tiles != '0;
  assign sched_busy = state != IDLE;
  assign sched_done = state == DONE;
  assign core_start = state == CFG;
  assign dma_req_valid = state == WT_REQ || state == IN_REQ;
  deit_tile_counter #(.K_W(K_W), .N_W(N_W)) u_cnt (
    .clk(clk), .rst_n(rst_n), .clear(start_ok), .step(state == NEXT),
    .k_tiles(k_tiles_q), .n_tiles(n_tiles_q),
    .k(k), .n(n), .k_last(k_last), .n_last(n_last)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = start_ok ? CFG : IDLE;
      CFG:      nxt = WT_REQ;
      WT_REQ:   nxt = dma_req_ready ? WT_WAIT : WT_REQ;
      WT_WAIT:  nxt = wt_loaded ? IN_REQ : WT_WAIT;
      IN_REQ:   nxt = dma_req_ready ? IN_WAIT : IN_REQ;
      IN_WAIT:  nxt = in_done ? (core_out_en ? OUT_WAIT : NEXT) : IN_WAIT;
      OUT_WAIT: nxt = out_tvalid && out_tready && out_tlast ? NEXT : OUT_WAIT;
      NEXT:     nxt = k_last && n_last ? DONE : CFG;
      default:  nxt = IDLE;
    endcase
    if (sched_abort) nxt = IDLE;
  end
  // Descriptor fields are registered one cycle ahead of valid so they are stable for the whole request.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      k_tiles_q     <= '0;
      n_tiles_q     <= '0;
      sched_err     <= 1'b0;
      core_acc_mode <= 1'b0;
      core_out_en   <= 1'b0;
      dma_req_type  <= DMA_TYPE_WEIGHT;
      dma_req_k     <= '0;
      dma_req_n     <= '0;
    end else begin
      state     <= nxt;
      sched_err <= start_req && !start_ok;
      if (start_ok) begin
        k_tiles_q <= cfg_k_tiles;
        n_tiles_q <= cfg_n_tiles;
      end
      if (state == CFG) begin
        core_acc_mode <= k != '0;
        core_out_en   <= k_last;
      end
      if (state == CFG || state == WT_WAIT) begin
        dma_req_type <= state == CFG ? DMA_TYPE_WEIGHT : DMA_TYPE_INPUT;
        dma_req_k    <= k;
        dma_req_n    <= state == CFG ? n : '0;
      end
    end
`ifdef DEIT_TILE_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (start_ok) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (sched_busy) begin
      perf_cycles <= perf_cycles + {31'd0, perf_cycles != '1};
      perf_stall  <= perf_stall + {31'd0, dma_req_valid && !dma_req_ready && perf_stall != '1};
    end
`endif
endmodule

// File: tb/tb_deit_tile_scheduler.sv
// tb_deit_tile_scheduler: scoreboard bench; stimulus pushes the expected descriptor stream, a monitor checks it.
module tb_deit_tile_scheduler;
  import deit_pkg::*;
  localparam int K_W = 8;
  localparam int N_W = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [K_W-1:0] cfg_k_tiles = '0;
  logic [N_W-1:0] cfg_n_tiles = '0;
  logic sched_start = 1'b0, sched_abort = 1'b0, dma_req_ready = 1'b0;
  logic wt_loaded = 1'b0, in_done = 1'b0, out_tvalid = 1'b0, out_tready = 1'b0, out_tlast = 1'b0;
  logic sched_busy, sched_done, sched_err, dma_req_valid, dma_req_type;
  logic core_start, core_acc_mode, core_out_en;
  logic [K_W-1:0] dma_req_k;
  logic [N_W-1:0] dma_req_n;
`ifdef DEIT_TILE_SCHED_PERF_EN
  logic [31:0] perf_cycles, perf_stall;
`endif
  typedef struct {
    logic typ;
    int   k;
    int   n;
    logic acc;
    logic oen;
  } desc_t;
  desc_t exp_q[$];
  int errors = 0, checks = 0;
  int n_start = 0, n_done = 0, n_err = 0, busy_cyc = 0, stall_cyc = 0;
  int rdy_mode = 0;
  logic pv = 1'b0, pr = 1'b0, pa = 1'b0, pt = 1'b0;
  logic [K_W-1:0] pk = '0;
  logic [N_W-1:0] pn = '0;

  always #5 clk = ~clk;

  deit_tile_scheduler #(.K_W(K_W), .N_W(N_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_k_tiles(cfg_k_tiles), .cfg_n_tiles(cfg_n_tiles),
    .sched_start(sched_start), .sched_abort(sched_abort), .sched_busy(sched_busy),
    .sched_done(sched_done), .sched_err(sched_err), .dma_req_valid(dma_req_valid),
    .dma_req_ready(dma_req_ready), .dma_req_type(dma_req_type), .dma_req_k(dma_req_k),
    .dma_req_n(dma_req_n), .wt_loaded(wt_loaded), .in_done(in_done), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .out_tlast(out_tlast), .core_start(core_start),
    .core_acc_mode(core_acc_mode), .core_out_en(core_out_en)
`ifdef DEIT_TILE_SCHED_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ready: 0 = always high, 1 = random, 2 = held low
  initial forever begin
    @(posedge clk);
    #1;
    dma_req_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ($urandom % 3) != 0 : 1'b0;
  end

  initial forever begin
    desc_t e;
    @(negedge clk);
    if (rst_n) begin
      if (pv && !pr && !pa) begin
        chk("valid_hold", dma_req_valid, 1);
        chk("desc_hold", {dma_req_type, dma_req_k, dma_req_n}, {pt, pk, pn});
      end
      if (sched_busy) busy_cyc++;
      if (sched_busy && dma_req_valid && !dma_req_ready) stall_cyc++;
      if (core_start) n_start++;
      if (sched_err) n_err++;
      if (sched_done) begin
        n_done++;
        chk("busy_in_done", sched_busy, 1);
      end
      if (dma_req_valid && dma_req_ready) begin
        if (exp_q.size() == 0) chk("unexpected_desc", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("desc_type", dma_req_type, e.typ);
          chk("desc_k", dma_req_k, e.k);
          chk("desc_n", dma_req_n, e.n);
          if (e.typ == DMA_TYPE_WEIGHT) begin
            chk("acc_mode", core_acc_mode, e.acc);
            chk("out_en", core_out_en, e.oen);
          end
        end
      end
    end
    pv = dma_req_valid;
    pr = dma_req_ready;
    pa = sched_abort || !rst_n;
    pt = dma_req_type;
    pk = dma_req_k;
    pn = dma_req_n;
  end

  task automatic pulse(input int which);
    repeat (3) @(posedge clk);
    #1;
    if (which == 0) wt_loaded = 1'b1;
    else if (which == 1) in_done = 1'b1;
    else begin
      out_tvalid = 1'b1;
      out_tready = 1'b1;
      out_tlast  = 1'b1;
    end
    @(posedge clk);
    #1;
    wt_loaded = 1'b0;
    in_done = 1'b0;
    out_tvalid = 1'b0;
    out_tready = 1'b0;
    out_tlast = 1'b0;
  endtask

  task automatic wait_hs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dma_req_valid && dma_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("hs_timeout", 0, 1);
  endtask

  task automatic run_job(input int kt, input int nt, input int abort_step, input bit out_stall);
    int s0, d0, b0, t0, step;
    bit ok;
    s0 = n_start;
    d0 = n_done;
    b0 = busy_cyc;
    t0 = stall_cyc;
    for (int n = 0; n < nt; n++)
      for (int k = 0; k < kt; k++) begin
        exp_q.push_back(desc_t'{DMA_TYPE_WEIGHT, k, n, k != 0, k == kt - 1});
        exp_q.push_back(desc_t'{DMA_TYPE_INPUT, k, 0, 1'b0, 1'b0});
      end
    @(posedge clk);
    #1;
    cfg_k_tiles = K_W'(kt);
    cfg_n_tiles = N_W'(nt);
    sched_start = 1'b1;
    @(posedge clk);
    #1;
    sched_start = 1'b0;
    step = 0;
    for (int n = 0; n < nt; n++)
      for (int k = 0; k < kt; k++) begin
        wait_hs(ok);
        if (!ok) begin
          exp_q.delete();
          return;
        end
        pulse(0);
        wait_hs(ok);
        if (!ok) begin
          exp_q.delete();
          return;
        end
        if (step == abort_step) begin
          @(posedge clk);
          #1 sched_abort = 1'b1;
          @(posedge clk);
          #1 sched_abort = 1'b0;
          @(negedge clk);
          chk("abort_busy", sched_busy, 0);
          chk("abort_valid", dma_req_valid, 0);
          exp_q.delete();
          repeat (10) @(negedge clk);
          chk("abort_no_done", n_done - d0, 0);
          chk("abort_starts", n_start - s0, abort_step + 1);
          chk("abort_idle", sched_busy, 0);
          return;
        end
        pulse(1);
        if (k == kt - 1) begin
          if (out_stall) begin
            repeat (3) @(posedge clk);
            #1;
            out_tvalid = 1'b1;
            out_tlast = 1'b1;
            out_tready = 1'b0;
            repeat (5) begin
              @(negedge clk);
              chk("out_wait_busy", sched_busy, 1);
            end
            chk("out_wait_starts", n_start - s0, step + 1);
            chk("out_wait_no_done", n_done - d0, 0);
            @(posedge clk);
            #1 out_tready = 1'b1;
            @(posedge clk);
            #1;
            out_tvalid = 1'b0;
            out_tready = 1'b0;
            out_tlast = 1'b0;
          end else pulse(2);
        end
        step++;
      end
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sched_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_seen", ok, 1);
    @(negedge clk);
    chk("job_starts", n_start - s0, kt * nt);
    chk("job_dones", n_done - d0, 1);
    chk("job_idle", sched_busy, 0);
    chk("job_q_empty", exp_q.size(), 0);
`ifdef DEIT_TILE_SCHED_PERF_EN
    chk("perf_cycles", perf_cycles, busy_cyc - b0);
    chk("perf_stall", perf_stall, stall_cyc - t0);
`endif
  endtask

  task automatic stall_watch();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = core_start;
    end
    chk("stall_cfg_seen", seen, 1);
    chk("cfg_valid_low", dma_req_valid, 0);
    chk("cfg_busy", sched_busy, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", dma_req_valid, 1);
      chk("stall_fields", {dma_req_type, dma_req_k, dma_req_n}, 0);
    end
    rdy_mode = 0;
  endtask

  initial begin
    int e0, s0;
    #2;
    chk("rst_busy", sched_busy, 0);
    chk("rst_done", sched_done, 0);
    chk("rst_err", sched_err, 0);
    chk("rst_valid", dma_req_valid, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_acc_oen", {core_acc_mode, core_out_en}, 0);
    chk("rst_desc", {dma_req_type, dma_req_k, dma_req_n}, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_job(2, 2, -1, 1'b0);
    for (int p = 0; p < 2; p++) begin
      e0 = n_err;
      s0 = n_start;
      @(posedge clk);
      #1;
      cfg_k_tiles = p == 0 ? K_W'(0) : K_W'(3);
      cfg_n_tiles = p == 0 ? N_W'(2) : N_W'(0);
      sched_start = 1'b1;
      @(posedge clk);
      #1 sched_start = 1'b0;
      repeat (5) begin
        @(negedge clk);
        chk("err_busy", sched_busy, 0);
        chk("err_valid", dma_req_valid, 0);
      end
      chk("err_pulses", n_err - e0, 1);
      chk("err_no_start", n_start - s0, 0);
    end
    e0 = n_err;
    @(posedge clk);
    #1;
    cfg_k_tiles = 8'd1;
    cfg_n_tiles = 8'd1;
    sched_start = 1'b1;
    sched_abort = 1'b1;
    @(posedge clk);
    #1;
    sched_start = 1'b0;
    sched_abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_start_idle", sched_busy, 0);
    chk("abort_start_no_err", n_err - e0, 0);
    rdy_mode = 2;
    @(posedge clk);
    @(negedge clk);
    fork
      run_job(1, 1, -1, 1'b0);
      stall_watch();
    join
`ifdef DEIT_TILE_SCHED_PERF_EN
    chk("perf_stall_10", perf_stall, 10);
`endif
    run_job(2, 1, -1, 1'b1);
    run_job(2, 2, 1, 1'b0);
    run_job(1, 1, -1, 1'b0);
    rdy_mode = 1;
    repeat (6) run_job($urandom_range(1, 4), $urandom_range(1, 3), -1, 1'b0);
    rdy_mode = 2;
    @(posedge clk);
    #1;
    cfg_k_tiles = 8'd1;
    cfg_n_tiles = 8'd1;
    sched_start = 1'b1;
    @(posedge clk);
    #1 sched_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", dma_req_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", dma_req_valid, 0);
    chk("async_rst_busy", sched_busy, 0);
    chk("async_rst_acc_oen", {core_acc_mode, core_out_en}, 0);
    chk("async_rst_desc", {dma_req_type, dma_req_k, dma_req_n}, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", sched_busy, 0);
    run_job(3, 2, -1, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
